// File: rtl/demux1_4_buf_pkg.sv
// -----------------------------------------------------------------------------
// demux1_4_buf_pkg
// Shared definitions for the 1-to-4 buffered demultiplexer:
//   - ARCH_WIDTH default payload width (64) when not supplied by the build
//   - DEMUX_PORTS / DEMUX_SEL_W geometry
//   - dest_e destination codes SEL_A..SEL_D (2'b00..2'b11)
//   - CNT_W width of the optional per-slot drain counters
//   - sel_decode(): binary select to one-hot slot vector
// Optional feature macro: DEMUX1_4_CNT_EN (drain counters).
// -----------------------------------------------------------------------------
`ifndef ARCH_WIDTH
`define ARCH_WIDTH 64
`endif

package demux1_4_buf_pkg;

  localparam int DEMUX_PORTS = 4;
  localparam int DEMUX_SEL_W = 2;
  localparam int CNT_W       = 32;

  typedef enum logic [DEMUX_SEL_W-1:0] {
    SEL_A = 2'b00,
    SEL_B = 2'b01,
    SEL_C = 2'b10,
    SEL_D = 2'b11
  } dest_e;

  function automatic logic [DEMUX_PORTS-1:0] sel_decode(input logic [DEMUX_SEL_W-1:0] sel);
    logic [DEMUX_PORTS-1:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
// One-entry output buffer for a single demux destination.
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset (clears full, data and counter)
//   load_i   write data_i into the slot this edge
//   ready_i  consumer ready; a full slot drains when this is high
//   data_i   payload to load
//   full_o   slot holds a beat
//   data_o   slot payload
//   cnt_o    (DEMUX1_4_CNT_EN only) completed drains, wraps at 2^32
// -----------------------------------------------------------------------------
`ifndef ARCH_WIDTH
`define ARCH_WIDTH 64
`endif

module demux_slot
  import demux1_4_buf_pkg::*;
#(
  parameter int DATA_W = `ARCH_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic [DATA_W-1:0] data_o
`ifdef DEMUX1_4_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt_o
`endif
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              drain;

  assign drain = full_q & ready_i;

  // A load on the same edge as a drain keeps the slot full with the new beat,
  // which is what sustains one beat per cycle per destination.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

`ifdef DEMUX1_4_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Natural modular add gives the 0xFFFFFFFF -> 0 wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (drain) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/demux1_4_buf.sv
// -----------------------------------------------------------------------------
// demux1_4_buf
// 1-to-4 demultiplexer with a one-entry registered buffer per destination.
// One valid/ready input stream is routed by in_sel into slot a/b/c/d; each
// slot drains to its own consumer with an independent valid/ready pair.
// Ports:
//   clk                 rising-edge clock
//   rst_n               synchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready depends on in_sel)
//   in_sel              destination: 00=a 01=b 10=c 11=d
//   in_data             payload
//   out_valid[3:0]      slot full flags (bit0=a .. bit3=d)
//   out_ready[3:0]      consumer ready per slot
//   out_data_a..d       slot payloads
//   cnt_a..d            (DEMUX1_4_CNT_EN only) per-slot drain counters
// Optional feature macro: DEMUX1_4_CNT_EN.
// -----------------------------------------------------------------------------
`ifndef ARCH_WIDTH
`define ARCH_WIDTH 64
`endif

module demux1_4_buf
  import demux1_4_buf_pkg::*;
#(
  parameter int DATA_W = `ARCH_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DEMUX_SEL_W-1:0] in_sel,
  input  logic [DATA_W-1:0]      in_data,
  output logic [DEMUX_PORTS-1:0] out_valid,
  input  logic [DEMUX_PORTS-1:0] out_ready,
  output logic [DATA_W-1:0]      out_data_a,
  output logic [DATA_W-1:0]      out_data_b,
  output logic [DATA_W-1:0]      out_data_c,
  output logic [DATA_W-1:0]      out_data_d
`ifdef DEMUX1_4_CNT_EN
  ,
  output logic [CNT_W-1:0]       cnt_a,
  output logic [CNT_W-1:0]       cnt_b,
  output logic [CNT_W-1:0]       cnt_c,
  output logic [CNT_W-1:0]       cnt_d
`endif
);

  logic [DEMUX_PORTS-1:0] full;
  logic [DEMUX_PORTS-1:0] sel_onehot;
  logic [DEMUX_PORTS-1:0] load_vec;
  logic                   accept;
  logic [DATA_W-1:0]      slot_data [DEMUX_PORTS];
`ifdef DEMUX1_4_CNT_EN
  logic [CNT_W-1:0]       slot_cnt  [DEMUX_PORTS];
`endif

  assign sel_onehot = sel_decode(in_sel);

  // Only the addressed slot gates the input: a stalled consumer blocks just
  // the beats aimed at it. A slot draining this cycle frees room for a load.
  assign in_ready = rst_n & (~full[in_sel] | out_ready[in_sel]);
  assign accept   = in_valid & in_ready;
  assign load_vec = sel_onehot & {DEMUX_PORTS{accept}};

  // Reset is synchronous, so the registered full flags only clear at the
  // edge; masking here keeps out_valid low for the whole reset window.
  assign out_valid = full & {DEMUX_PORTS{rst_n}};

  for (genvar i = 0; i < DEMUX_PORTS; i++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load_vec[i]),
      .ready_i (out_ready[i]),
      .data_i  (in_data),
      .full_o  (full[i]),
      .data_o  (slot_data[i])
`ifdef DEMUX1_4_CNT_EN
      ,
      .cnt_o   (slot_cnt[i])
`endif
    );
  end

  assign out_data_a = slot_data[SEL_A];
  assign out_data_b = slot_data[SEL_B];
  assign out_data_c = slot_data[SEL_C];
  assign out_data_d = slot_data[SEL_D];

`ifdef DEMUX1_4_CNT_EN
  assign cnt_a = slot_cnt[SEL_A];
  assign cnt_b = slot_cnt[SEL_B];
  assign cnt_c = slot_cnt[SEL_C];
  assign cnt_d = slot_cnt[SEL_D];
`endif

endmodule
